// File: rtl/harris_score_pipe.sv
// harris_score_pipe: Harris corner response accumulated over non-overlapping WIN*WIN gradient windows.
// Define HARRIS_THRESH_EN to build the registered (score > thresh) corner flag; otherwise is_corner is tied low.
module harris_score_pipe #(
    parameter int GW      = 16,
    parameter int WIN     = 4,
    parameter int K_NUM   = 5,
    parameter int K_SHIFT = 7,
    parameter int OW      = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [GW-1:0] gx,
    input  logic signed [GW-1:0] gy,
    input  logic signed [OW-1:0] thresh,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] r_score,
    output logic                 is_corner
);

    localparam int N   = WIN * WIN;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int AW  = 2 * GW + $clog2(N);
    localparam int SW  = 2 * GW;
    localparam int PW  = 2 * AW;
    localparam int TW  = AW + 1;
    localparam int TW2 = 2 * TW;
    localparam int KW  = $clog2(K_NUM + 1) + 1;
    localparam int FW0 = TW2 + KW + 1;
    localparam int FW  = (FW0 > OW) ? FW0 : OW;

    typedef enum logic [1:0] {ACC, P1, P2, OUT} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   accept;
    logic                   handshake;

    logic signed [SW-1:0]   sq_xx_p0, sq_yy_p0, sq_xy_p0;
    logic                   vld_p0;

    logic signed [AW-1:0]   sxx_q, syy_q, sxy_q;
    logic signed [AW-1:0]   sxx_d, syy_d, sxy_d;
    logic signed [TW-1:0]   trace;

    logic signed [PW-1:0]   pxx_p1, pxy_p1;
    logic signed [TW2-1:0]  ptt_p1;

    logic signed [OW-1:0]   score_next;
    logic signed [OW-1:0]   r_score_q;
    logic                   out_valid_q;

    // Full-width response; only the final result wraps to OW bits.
    function automatic logic signed [OW-1:0] harris_score(
        input logic signed [PW-1:0]  pxx,
        input logic signed [PW-1:0]  pxy,
        input logic signed [TW2-1:0] ptt
    );
        logic signed [FW-1:0] a, b, c, kt, full;
        a    = FW'(pxx);
        b    = FW'(pxy);
        c    = FW'(ptt);
        kt   = (FW'(K_NUM) * c) >>> K_SHIFT;
        full = a - b - kt;
        return full[OW-1:0];
    endfunction

    assign in_ready  = (state_q == ACC);
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign r_score   = r_score_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ACC: begin
                if (accept) begin
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = P1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            // Wait for the last registered square to land in the accumulators.
            P1:      if (!vld_p0) state_d = P2;
            P2:      state_d = OUT;
            OUT:     if (out_ready) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stage p0: per-sample squares and cross product.
    always_ff @(posedge clk) begin
        if (accept) begin
            sq_xx_p0 <= SW'(gx) * SW'(gx);
            sq_yy_p0 <= SW'(gy) * SW'(gy);
            sq_xy_p0 <= SW'(gx) * SW'(gy);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) vld_p0 <= 1'b0;
        else     vld_p0 <= accept;
    end

    always_comb begin
        sxx_d = sxx_q;
        syy_d = syy_q;
        sxy_d = sxy_q;
        if (handshake) begin
            sxx_d = '0;
            syy_d = '0;
            sxy_d = '0;
        end else if (vld_p0) begin
            sxx_d = sxx_q + AW'(sq_xx_p0);
            syy_d = syy_q + AW'(sq_yy_p0);
            sxy_d = sxy_q + AW'(sq_xy_p0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sxx_q <= '0;
            syy_q <= '0;
            sxy_q <= '0;
        end else begin
            sxx_q <= sxx_d;
            syy_q <= syy_d;
            sxy_q <= sxy_d;
        end
    end

    assign trace = TW'(sxx_q) + TW'(syy_q);

    // Stage p1: window products.
    always_ff @(posedge clk) begin
        if (rst) begin
            pxx_p1 <= '0;
            pxy_p1 <= '0;
            ptt_p1 <= '0;
        end else if (state_q == P1) begin
            pxx_p1 <= PW'(sxx_q) * PW'(syy_q);
            pxy_p1 <= PW'(sxy_q) * PW'(sxy_q);
            ptt_p1 <= TW2'(trace) * TW2'(trace);
        end
    end

    assign score_next = harris_score(pxx_p1, pxy_p1, ptt_p1);

    // Stage p2: response register and output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_score_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (state_q == P2) begin
            r_score_q   <= score_next;
            out_valid_q <= 1'b1;
        end else if (handshake) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef HARRIS_THRESH_EN
    logic is_corner_q;

    always_ff @(posedge clk) begin
        if (rst)                is_corner_q <= 1'b0;
        else if (state_q == P2) is_corner_q <= (score_next > thresh);
    end

    assign is_corner = is_corner_q;
`else
    logic unused_thresh;

    assign unused_thresh = ^thresh;
    assign is_corner     = 1'b0;
`endif

endmodule

// File: tb/tb_harris_score_pipe.sv
// Bench for harris_score_pipe: directed windows plus randomized windows scored by a window-level model.
module tb_harris_score_pipe;

    localparam int GW      = 16;
    localparam int WIN     = 4;
    localparam int N       = WIN * WIN;
    localparam int K_NUM   = 5;
    localparam int K_SHIFT = 7;
    localparam int OW      = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [GW-1:0] gx, gy;
    logic signed [OW-1:0] thresh;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] r_score;
    logic                 is_corner;

    int checks = 0;
    int errors = 0;

    logic signed [GW-1:0] wx[N];
    logic signed [GW-1:0] wy[N];

    harris_score_pipe #(
        .GW(GW), .WIN(WIN), .K_NUM(K_NUM), .K_SHIFT(K_SHIFT), .OW(OW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .gx(gx), .gy(gy), .thresh(thresh), .out_valid(out_valid),
        .out_ready(out_ready), .r_score(r_score), .is_corner(is_corner)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic signed [OW-1:0] obs, input logic signed [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Window sums, then the Harris formula on wide integers, wrapped to OW bits at the end.
    function automatic logic signed [OW-1:0] model_score();
        longint sxx, syy, sxy;
        logic signed [127:0] det_a, det_b, tr, tt, kt, r;
        sxx = 0;
        syy = 0;
        sxy = 0;
        for (int i = 0; i < N; i++) begin
            sxx += longint'(wx[i]) * longint'(wx[i]);
            syy += longint'(wy[i]) * longint'(wy[i]);
            sxy += longint'(wx[i]) * longint'(wy[i]);
        end
        det_a = 128'(sxx) * 128'(syy);
        det_b = 128'(sxy) * 128'(sxy);
        tr    = 128'(sxx + syy);
        tt    = tr * tr;
        kt    = (128'(K_NUM) * tt) >>> K_SHIFT;
        r     = det_a - det_b - kt;
        return r[OW-1:0];
    endfunction

    task automatic set_window(input logic signed [GW-1:0] ax, input logic signed [GW-1:0] ay);
        for (int i = 0; i < N; i++) begin
            wx[i] = ax;
            wy[i] = ay;
        end
    endtask

    task automatic feed(input int first, input int last, input int gap_pct);
        for (int i = first; i < last; i++) begin
            int t;
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                gx = GW'($urandom);
                step();
            end
            in_valid = 1'b1;
            gx = wx[i];
            gy = wy[i];
            t = 0;
            while (!in_ready && t < 50) begin
                step();
                t++;
            end
            if (t >= 50) begin
                errors++;
                $error("FAIL feed_timeout: in_ready observed 0 expected 1");
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_window(input logic signed [OW-1:0] exp_r, input int hold, input logic iv_hold);
        logic exp_c;
`ifdef HARRIS_THRESH_EN
        exp_c = (exp_r > thresh);
`else
        exp_c = 1'b0;
`endif
        in_valid = iv_hold;
        gx = 16'sd7;
        gy = -16'sd5;
        step();
        chk_bit("lat1_out_valid", out_valid, 1'b0);
        chk_bit("lat1_in_ready", in_ready, 1'b0);
        step();
        chk_bit("lat2_out_valid", out_valid, 1'b0);
        step();
        chk_bit("lat3_out_valid", out_valid, 1'b1);
        chk_val("r_score", r_score, exp_r);
        chk_bit("is_corner", is_corner, exp_c);
        for (int h = 0; h < hold; h++) begin
            gx = GW'($urandom);
            step();
            chk_bit("hold_out_valid", out_valid, 1'b1);
            chk_val("hold_r_score", r_score, exp_r);
            chk_bit("hold_is_corner", is_corner, exp_c);
            chk_bit("hold_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk_bit("hs_out_valid", out_valid, 1'b0);
        chk_bit("hs_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        gx = '0; gy = '0; thresh = '0;
        repeat (3) step();
        rst = 1'b0;
        chk_bit("rst_in_ready", in_ready, 1'b1);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_val("rst_r_score", r_score, '0);
        chk_bit("rst_is_corner", is_corner, 1'b0);

        // Single-axis gradient.
        set_window(16'sd1, 16'sd0);
        feed(0, N, 0);
        finish_window(-64'sd10, 0, 1'b0);

        // Diagonal edge, equal gradients.
        set_window(16'sd1, 16'sd1);
        feed(0, N, 0);
        finish_window(-64'sd40, 1, 1'b0);

        // Two orthogonal halves form a corner.
        thresh = 64'sd10000;
        for (int i = 0; i < N; i++) begin
            wx[i] = (i < N / 2) ? 16'sd4 : 16'sd0;
            wy[i] = (i < N / 2) ? 16'sd0 : 16'sd4;
        end
        feed(0, N, 0);
        finish_window(64'sd13824, 0, 1'b0);

        // Negative cross term.
        thresh = 64'sd0;
        set_window(-16'sd3, 16'sd3);
        feed(0, N, 0);
        finish_window(-64'sd3240, 0, 1'b0);

        // Consumer stall with in_valid held high, then a gapped window.
        set_window(16'sd2, 16'sd1);
        feed(0, N, 0);
        finish_window(-64'sd250, 5, 1'b1);
        set_window(16'sd1, 16'sd1);
        feed(0, N, 40);
        finish_window(-64'sd40, 0, 1'b0);

        // Reset mid-window, colliding with an offered sample.
        set_window(16'sd1, 16'sd0);
        feed(0, 7, 0);
        rst = 1'b1; in_valid = 1'b1; gx = 16'sd9; gy = 16'sd9;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk_bit("midrst_in_ready", in_ready, 1'b1);
        chk_bit("midrst_out_valid", out_valid, 1'b0);
        set_window(16'sd1, 16'sd0);
        feed(0, N, 0);
        finish_window(-64'sd10, 0, 1'b0);

        // Reset discards a pending score, even with out_ready high.
        set_window(16'sd3, -16'sd2);
        feed(0, N, 0);
        repeat (3) step();
        chk_bit("pend_out_valid", out_valid, 1'b1);
        rst = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; out_ready = 1'b0;
        chk_bit("pendrst_out_valid", out_valid, 1'b0);
        chk_val("pendrst_r_score", r_score, '0);
        chk_bit("pendrst_is_corner", is_corner, 1'b0);
        chk_bit("pendrst_in_ready", in_ready, 1'b1);

        // Randomized windows, including full-scale extremes and threshold boundaries.
        for (int w = 0; w < 12; w++) begin
            logic signed [OW-1:0] er;
            for (int i = 0; i < N; i++) begin
                if (w % 4 == 0) begin
                    wx[i] = ($urandom_range(1) == 1) ? 16'sh8000 : 16'sh7fff;
                    wy[i] = ($urandom_range(1) == 1) ? 16'sh8000 : 16'sh7fff;
                end else begin
                    wx[i] = GW'($urandom);
                    wy[i] = GW'($urandom);
                end
            end
            er = model_score();
            if (w % 2 == 0) thresh = er + $signed(64'($urandom_range(2))) - 64'sd1;
            else            thresh = {$urandom, $urandom};
            feed(0, N, 30);
            finish_window(er, int'($urandom_range(3)), 1'($urandom_range(1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
